// File: rtl/program_loader.sv
// program_loader: writer side of the CPU instruction memory.
//
// Accepts 8-bit instruction words ({function, value}) over a valid/ready
// handshake and stores them in a DEPTH-entry program store. The unused tail
// of the store is zero-filled, so it reads as NOPs. The CPU fetches through
// a combinational read port, and is held via cpu_hold for the whole load.
//
// Ports:
//   clk, reset              - clock; synchronous active-high reset
//   start                   - one-cycle pulse, begins a load when idle
//   in_valid/in_ready       - source handshake
//   in_function/in_value    - instruction nibbles
//   in_last                 - final word of the program
//   rd_addr                 - fetch address from the PC
//   memoryFunction/Value    - fetched word; forced to 0 while cpu_hold is high
//   cpu_hold                - high in LOAD, FILL and DONE
//   load_done               - one-cycle pulse in DONE
//   overflow                - sticky: program ran past DEPTH without in_last
//   word_count              - words accepted in the last/current load
module program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_function,
  input  logic [3:0]        in_value,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        memoryFunction,
  output logic [3:0]        memoryValue,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                overflow_reg, overflow_next;
  logic                wr_en;
  logic [7:0]          wr_data;
  logic [7:0]          mem_reg [DEPTH];
  logic [7:0]          rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    wr_en         = 1'b0;
    wr_data       = 8'h00;
    in_ready      = 1'b0;
    cpu_hold      = 1'b1;
    load_done     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cpu_hold = 1'b0;
        if (start) begin
          state_next    = LOAD;
          ptr_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en      = 1'b1;
          wr_data    = {in_function, in_value};
          count_next = count_reg + 1'b1;
          if (ptr_reg == LAST_ADDR) begin
            // Store is full: the pointer parks here rather than wrapping.
            // Without in_last the program did not fit.
            overflow_next = ~in_last;
            state_next    = DONE;
          end else begin
            ptr_next = ptr_reg + 1'b1;
            if (in_last) state_next = FILL;
          end
        end
      end
      FILL: begin
        // One NOP per cycle from the first unwritten slot to the end.
        wr_en = 1'b1;
        if (ptr_reg == LAST_ADDR) state_next = DONE;
        else                      ptr_next   = ptr_reg + 1'b1;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Program store: every entry clears on reset so an interrupted load
  // leaves no partial program behind.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (reset)
          mem_reg[gi] <= 8'h00;
        else if (wr_en && ptr_reg == ADDR_W'(gi))
          mem_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign rd_data        = cpu_hold ? 8'h00 : mem_reg[rd_addr];
  assign memoryFunction = rd_data[7:4];
  assign memoryValue    = rd_data[3:0];
  assign overflow       = overflow_reg;
  assign word_count     = count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. Stimulus pushes expectations into queues;
// a monitor on the falling edge pops and compares them whenever a probe is
// raised or the DUT pulses load_done.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_function = '0;
  logic [3:0] in_value = '0;
  logic       in_last = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [3:0] memoryFunction;
  logic [3:0] memoryValue;
  logic       cpu_hold;
  logic       load_done;
  logic       overflow;
  logic [4:0] word_count;

  int errors = 0;
  int checks = 0;

  program_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_function(in_function), .in_value(in_value), .in_last(in_last),
    .rd_addr(rd_addr), .memoryFunction(memoryFunction), .memoryValue(memoryValue),
    .cpu_hold(cpu_hold), .load_done(load_done), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // kind 0: memory read {0,function,value}
  // kind 1: status {in_ready,cpu_hold,load_done,overflow,word_count}
  typedef struct {
    int         kind;
    logic [8:0] exp;
    string      name;
  } probe_t;

  typedef struct {
    int wc;
    int ovf;
    int fill;
    int hs;
  } done_t;

  probe_t probe_q[$];
  done_t  done_q[$];
  logic   probe_valid = 1'b0;
  logic [7:0] exp_img [16];

  // ---------------- monitor ----------------
  int fill_cnt = 0;
  int hs_cnt = 0;

  always @(negedge clk) begin
    logic [8:0] act;
    probe_t p;
    done_t  d;
    if (probe_valid) begin
      checks++;
      if (probe_q.size() == 0) begin
        errors++;
        $display("FAIL probe_underflow: got probe with no expectation");
      end else begin
        p = probe_q.pop_front();
        if (p.kind == 0) act = {1'b0, memoryFunction, memoryValue};
        else             act = {in_ready, cpu_hold, load_done, overflow, word_count};
        if (act !== p.exp) begin
          errors++;
          $display("FAIL %s: got %h want %h", p.name, act, p.exp);
        end else
          $display("check %s: %h ok", p.name, act);
      end
    end
    if (reset) begin
      fill_cnt = 0;
      hs_cnt   = 0;
    end else begin
      if (in_valid && in_ready) hs_cnt++;
      if (cpu_hold && !in_ready && !load_done) fill_cnt++;
      if (load_done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load_done: wc=%0d", word_count);
        end else begin
          d = done_q.pop_front();
          if (word_count !== 5'(d.wc) || overflow !== 1'(d.ovf) ||
              fill_cnt != d.fill || hs_cnt != d.hs) begin
            errors++;
            $display("FAIL load_done: got wc=%0d ovf=%0d fill=%0d hs=%0d want wc=%0d ovf=%0d fill=%0d hs=%0d",
                     word_count, overflow, fill_cnt, hs_cnt, d.wc, d.ovf, d.fill, d.hs);
          end else
            $display("check load_done: wc=%0d ovf=%0d fill=%0d hs=%0d ok",
                     word_count, overflow, fill_cnt, hs_cnt);
        end
        fill_cnt = 0;
        hs_cnt   = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_status(input string name, input logic [8:0] exp);
    probe_t p;
    p.kind = 1; p.exp = exp; p.name = name;
    probe_q.push_back(p);
    probe_valid = 1'b1;
    tick();
    probe_valid = 1'b0;
  endtask

  task automatic check_image(input string name);
    probe_t p;
    for (int a = 0; a < 16; a++) begin
      p.kind = 0; p.exp = {1'b0, exp_img[a]};
      p.name = $sformatf("%s_addr%0d", name, a);
      probe_q.push_back(p);
      rd_addr = 4'(a);
      probe_valid = 1'b1;
      tick();
    end
    probe_valid = 1'b0;
  endtask

  task automatic expect_done(input int wc, input int ovf, input int fill, input int hs);
    done_t d;
    d.wc = wc; d.ovf = ovf; d.fill = fill; d.hs = hs;
    done_q.push_back(d);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] f, input logic [3:0] v, input logic last);
    bit sent = 0;
    in_function = f; in_value = v; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 20 && !sent; n++) begin
      if (in_ready) sent = 1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!sent) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int n = 0; n < 40 && !idle; n++) begin
      if (!cpu_hold) idle = 1;
      else tick();
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got cpu_hold=1 want 0");
    end
  endtask

  task automatic clear_img();
    for (int a = 0; a < 16; a++) exp_img[a] = 8'h00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset check
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    probe_status("reset_status", 9'h000);
    clear_img();
    check_image("reset");

    // Short program, back-to-back
    do_start();
    expect_done(3, 0, 13, 3);
    send(4'h1, 4'h5, 1'b0);
    send(4'h2, 4'h3, 1'b0);
    send(4'h4, 4'h9, 1'b1);
    wait_idle();
    probe_status("short_status", {4'b0000, 5'd3});
    clear_img();
    exp_img[0] = 8'h15; exp_img[1] = 8'h23; exp_img[2] = 8'h49;
    check_image("short");

    // Full and overflow; 17th word offered during DONE
    do_start();
    expect_done(16, 1, 0, 16);
    for (int i = 0; i < 16; i++) send(4'hA, 4'(i), 1'b0);
    in_function = 4'h5; in_value = 4'hE; in_valid = 1'b1;
    probe_status("overflow_done", {4'b0111, 5'd16});
    tick(); tick();
    in_valid = 1'b0;
    wait_idle();
    probe_status("overflow_status", {4'b0001, 5'd16});
    for (int a = 0; a < 16; a++) exp_img[a] = {4'hA, 4'(a)};
    check_image("overflow");

    // Exact fill: DONE directly after 16th transfer, overflow cleared
    do_start();
    expect_done(16, 0, 0, 16);
    for (int i = 0; i < 16; i++) send(4'hC, 4'(15 - i), (i == 15));
    probe_status("exact_done", {4'b0110, 5'd16});
    wait_idle();
    probe_status("exact_status", {4'b0000, 5'd16});
    for (int a = 0; a < 16; a++) exp_img[a] = {4'hC, 4'(15 - a)};
    check_image("exact");

    // Gaps between words
    do_start();
    expect_done(3, 0, 13, 3);
    send(4'h1, 4'h5, 1'b0);
    tick(); tick();
    send(4'h2, 4'h3, 1'b0);
    tick(); tick();
    send(4'h4, 4'h9, 1'b1);
    wait_idle();
    probe_status("gaps_status", {4'b0000, 5'd3});
    clear_img();
    exp_img[0] = 8'h15; exp_img[1] = 8'h23; exp_img[2] = 8'h49;
    check_image("gaps");

    // Reset mid-load with an ignored start
    do_start();
    for (int i = 0; i < 5; i++) send(4'h7, 4'(i + 1), 1'b0);
    do_start();
    probe_status("midload_status", {4'b1100, 5'd5});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    probe_status("after_reset_status", 9'h000);
    clear_img();
    check_image("after_reset");

    tick(); tick();
    checks++;
    if (probe_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got probes=%0d dones=%0d want 0 0",
               probe_q.size(), done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
